count_down_especial: RTL



---
 rtl/count_down_especial.sv | 117 +++++++++++
 1 files changed

// File: rtl/count_down_especial.sv
// -----------------------------------------------------------------------------
// count_down_especial
//
// Programmable down-counter stepping by 1 or 2 per cycle. A start value is
// loaded in IDLE, counted down to zero in RUN, and a single-cycle DONE state
// flags completion. A sticky 'clipped' flag records that the final step was
// a step of 2 taken from a count of 1 (the counter saturates at 0 instead of
// wrapping).
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   rst       in   synchronous reset, active-high, overrides everything
//   load      in   load load_val into the counter (IDLE only)
//   load_val  in   [WIDTH-1:0] start value, unsigned
//   start     in   begin counting (IDLE only)
//   ctrl      in   step select in RUN: 1 -> step 2, 0 -> step 1
//   pause     in   hold count and state in RUN
//   count     out  [WIDTH-1:0] current counter value, registered
//   busy      out  high while in RUN
//   done      out  one-cycle pulse while in DONE
//   clipped   out  sticky: last step would have gone below zero
// -----------------------------------------------------------------------------
module count_down_especial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             ctrl,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             clipped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             clipped_next;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] eff_count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of the
    // order in which the simulator evaluates processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            clipped <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            clipped <= clipped_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; any path that
        // left one unassigned would otherwise infer a latch.
        state_next   = state;
        count_next   = count;
        clipped_next = clipped;
        step         = ctrl ? WIDTH'(2) : WIDTH'(1);
        // A same-cycle load feeds the start decision directly.
        eff_count    = load ? load_val : count;

        case (state)
            IDLE: begin
                if (load) begin
                    count_next   = load_val;
                    clipped_next = 1'b0;
                end
                if (start) begin
                    state_next = (eff_count != '0) ? RUN : DONE;
                end
            end

            RUN: begin
                if (!pause) begin
                    if (count > step) begin
                        count_next = count - step;
                    end else begin
                        // Saturate at zero; a step of 2 from 1 is the only
                        // case where the step exceeds the remaining count.
                        count_next   = '0;
                        clipped_next = clipped | (count < step);
                        state_next   = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Flags decoded from the state register only: no input-to-output paths.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
